// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode/funct constants, ALU-control encodings and control bundles for pipe_ctrl_unit.
// Optional build macro PIPE_CTRL_LINK_EN adds a link flag as the write-back bundle MSB.
package pipe_ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SRL = 4'b0011,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_XOR = 4'b1001,
    ALU_SLL = 4'b1010,
    ALU_SRA = 4'b1011,
    ALU_NOR = 4'b1100
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_JALR = 6'b001001;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  typedef struct packed {
    logic    reg_dst;
    logic    alu_src;
    alu_op_t alu_op;
  } ex_ctrl_t;

  typedef struct packed {
    logic branch;
    logic mem_read;
    logic mem_write;
  } mem_ctrl_t;

  typedef struct packed {
`ifdef PIPE_CTRL_LINK_EN
    logic link;
`endif
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  localparam int unsigned WB_W = $bits(wb_ctrl_t);

  typedef struct packed {
    ex_ctrl_t  ex;
    mem_ctrl_t mem;
    wb_ctrl_t  wb;
    logic      jump;
  } dec_ctrl_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// ID-stage inputs and per-stage control outputs of pipe_ctrl_unit.
// wb_ctrl is 3 bits wide when PIPE_CTRL_LINK_EN is defined, otherwise 2.
interface pipe_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned ALUC_W = 4
) ();

  logic              id_valid;
  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_rd;
  logic              ex_branch_taken;
  logic [ALUC_W+1:0] ex_ctrl;
  logic [2:0]        mem_ctrl;
  logic [WB_W-1:0]   wb_ctrl;
  logic [REG_AW-1:0] wb_dst;
  logic              id_jump;
  logic              stall;
  logic              flush;

  modport slave (
    input  id_valid, opcode, funct, id_rs, id_rt, id_rd, ex_branch_taken,
    output ex_ctrl, mem_ctrl, wb_ctrl, wb_dst, id_jump, stall, flush
  );

  modport master (
    output id_valid, opcode, funct, id_rs, id_rt, id_rd, ex_branch_taken,
    input  ex_ctrl, mem_ctrl, wb_ctrl, wb_dst, id_jump, stall, flush
  );

endinterface

// File: rtl/pipe_ctrl_decode.sv
// Combinational opcode/funct decode into the per-stage control bundles.
// With PIPE_CTRL_LINK_EN, jal/jalr also write back and raise the link flag.
module pipe_ctrl_decode
  import pipe_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output dec_ctrl_t  dec
);

  always_comb begin
    dec = '0;
    if (opcode == OP_RTYPE) begin
      dec.ex.reg_dst   = 1'b1;
      dec.wb.reg_write = 1'b1;
      case (funct)
        FN_ADD:  dec.ex.alu_op = ALU_ADD;
        FN_SUB:  dec.ex.alu_op = ALU_SUB;
        FN_AND:  dec.ex.alu_op = ALU_AND;
        FN_OR:   dec.ex.alu_op = ALU_OR;
        FN_XOR:  dec.ex.alu_op = ALU_XOR;
        FN_NOR:  dec.ex.alu_op = ALU_NOR;
        FN_SLL:  dec.ex.alu_op = ALU_SLL;
        FN_SRL:  dec.ex.alu_op = ALU_SRL;
        FN_SRA:  dec.ex.alu_op = ALU_SRA;
        FN_SLT:  dec.ex.alu_op = ALU_SLT;
        FN_JR: begin
          dec.jump         = 1'b1;
          dec.wb.reg_write = 1'b0;
        end
        FN_JALR: begin
          dec.jump         = 1'b1;
`ifdef PIPE_CTRL_LINK_EN
          dec.wb.link      = 1'b1;
`else
          dec.wb.reg_write = 1'b0;
`endif
        end
        default: dec = '0;
      endcase
    end else begin
      dec.ex.alu_src = 1'b1;
      case (opcode)
        OP_ADDI: begin dec.ex.alu_op = ALU_ADD; dec.wb.reg_write = 1'b1; end
        OP_SLTI: begin dec.ex.alu_op = ALU_SLT; dec.wb.reg_write = 1'b1; end
        OP_ANDI: begin dec.ex.alu_op = ALU_AND; dec.wb.reg_write = 1'b1; end
        OP_ORI:  begin dec.ex.alu_op = ALU_OR;  dec.wb.reg_write = 1'b1; end
        OP_XORI: begin dec.ex.alu_op = ALU_XOR; dec.wb.reg_write = 1'b1; end
        OP_LW: begin
          dec.ex.alu_op     = ALU_ADD;
          dec.mem.mem_read  = 1'b1;
          dec.wb.reg_write  = 1'b1;
          dec.wb.mem_to_reg = 1'b1;
        end
        OP_SW: begin
          dec.ex.alu_op     = ALU_ADD;
          dec.mem.mem_write = 1'b1;
        end
        OP_BEQ, OP_BNE: begin
          dec.ex.alu_op  = ALU_SUB;
          dec.mem.branch = 1'b1;
        end
        OP_J: dec.jump = 1'b1;
        OP_JAL: begin
          dec.jump = 1'b1;
`ifdef PIPE_CTRL_LINK_EN
          dec.wb.reg_write = 1'b1;
          dec.wb.link      = 1'b1;
`endif
        end
        default: dec = '0;
      endcase
    end
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control: decode, load-use stall / branch flush, ID/EX -> EX/MEM -> MEM/WB control registers.
// PIPE_CTRL_LINK_EN routes jal's destination to register 31 and carries the link flag.
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned ALUC_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  pipe_ctrl_if.slave bus
);

  typedef struct packed {
    ex_ctrl_t          ex;
    mem_ctrl_t         mem;
    wb_ctrl_t          wb;
    logic [REG_AW-1:0] dst;
  } id_ex_t;

  dec_ctrl_t         dec;
  id_ex_t            id_ex_q, id_ex_d;
  mem_ctrl_t         ex_mem_mem_q;
  wb_ctrl_t          ex_mem_wb_q, mem_wb_wb_q;
  logic [REG_AW-1:0] ex_mem_dst_q, mem_wb_dst_q;
  logic [REG_AW-1:0] id_dst;
  logic [ALUC_W-1:0] aluc;
  logic              hazard, stall_i, bubble;

  pipe_ctrl_decode u_decode (
    .opcode (bus.opcode),
    .funct  (bus.funct),
    .dec    (dec)
  );

  always_comb begin
    id_dst = dec.ex.reg_dst ? bus.id_rd : bus.id_rt;
`ifdef PIPE_CTRL_LINK_EN
    if (bus.opcode == OP_JAL) id_dst = REG_AW'(31);
`endif
  end

  // A taken branch squashes ID anyway, so it overrides the load-use stall.
  always_comb begin
    hazard  = bus.id_valid && id_ex_q.mem.mem_read && (id_ex_q.dst != '0) &&
              ((id_ex_q.dst == bus.id_rs) || (id_ex_q.dst == bus.id_rt));
    stall_i = hazard && !bus.ex_branch_taken;
    bubble  = !bus.id_valid || stall_i || bus.ex_branch_taken;
    id_ex_d = '0;
    if (!bubble) begin
      id_ex_d.ex  = dec.ex;
      id_ex_d.mem = dec.mem;
      id_ex_d.wb  = dec.wb;
      id_ex_d.dst = id_dst;
      if (id_dst == '0) id_ex_d.wb.reg_write = 1'b0;
    end
  end

  always_comb begin
    aluc          = '0;
    aluc[3:0]     = id_ex_q.ex.alu_op;
    bus.ex_ctrl   = {id_ex_q.ex.reg_dst, id_ex_q.ex.alu_src, aluc};
    bus.mem_ctrl  = ex_mem_mem_q;
    bus.wb_ctrl   = mem_wb_wb_q;
    bus.wb_dst    = mem_wb_dst_q;
    bus.stall     = stall_i;
    bus.flush     = bus.ex_branch_taken;
    bus.id_jump   = dec.jump && bus.id_valid && !stall_i && !bus.ex_branch_taken;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex_q      <= '0;
      ex_mem_mem_q <= '0;
      ex_mem_wb_q  <= '0;
      ex_mem_dst_q <= '0;
      mem_wb_wb_q  <= '0;
      mem_wb_dst_q <= '0;
    end else begin
      id_ex_q      <= id_ex_d;
      ex_mem_mem_q <= id_ex_q.mem;
      ex_mem_wb_q  <= id_ex_q.wb;
      ex_mem_dst_q <= id_ex_q.dst;
      mem_wb_wb_q  <= ex_mem_wb_q;
      mem_wb_dst_q <= ex_mem_dst_q;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: directed scenarios plus random traffic against a table model.
// Expectations follow PIPE_CTRL_LINK_EN when the bench is built with it.
module tb_pipe_ctrl_unit;

`ifdef PIPE_CTRL_LINK_EN
  localparam logic LINK = 1'b1;
  localparam int   WBW  = 3;
`else
  localparam logic LINK = 1'b0;
  localparam int   WBW  = 2;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.REG_AW(5), .ALUC_W(4)) bus ();

  pipe_ctrl_unit #(.REG_AW(5), .ALUC_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [5:0] ex;
    logic [2:0] mem;
    logic [2:0] wb;   // {link, RegWrite, MemtoReg}
    logic [4:0] dst;
  } stage_t;

  stage_t pipe [3];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {jump, RegDst ALUSrc ALUControl, Branch MemRead MemWrite, link RegWrite MemtoReg}
  function automatic logic [12:0] ref_dec(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: case (fn)
        6'h20: return {1'b0, 6'b100010, 3'b000, 3'b010};
        6'h22: return {1'b0, 6'b100110, 3'b000, 3'b010};
        6'h24: return {1'b0, 6'b100000, 3'b000, 3'b010};
        6'h25: return {1'b0, 6'b100001, 3'b000, 3'b010};
        6'h26: return {1'b0, 6'b101001, 3'b000, 3'b010};
        6'h27: return {1'b0, 6'b101100, 3'b000, 3'b010};
        6'h00: return {1'b0, 6'b101010, 3'b000, 3'b010};
        6'h02: return {1'b0, 6'b100011, 3'b000, 3'b010};
        6'h03: return {1'b0, 6'b101011, 3'b000, 3'b010};
        6'h2a: return {1'b0, 6'b100111, 3'b000, 3'b010};
        6'h08: return {1'b1, 6'b100000, 3'b000, 3'b000};
        6'h09: return {1'b1, 6'b100000, 3'b000, LINK, LINK, 1'b0};
        default: return '0;
      endcase
      6'h08: return {1'b0, 6'b010010, 3'b000, 3'b010};
      6'h0a: return {1'b0, 6'b010111, 3'b000, 3'b010};
      6'h0c: return {1'b0, 6'b010000, 3'b000, 3'b010};
      6'h0d: return {1'b0, 6'b010001, 3'b000, 3'b010};
      6'h0e: return {1'b0, 6'b011001, 3'b000, 3'b010};
      6'h23: return {1'b0, 6'b010010, 3'b010, 3'b011};
      6'h2b: return {1'b0, 6'b010010, 3'b001, 3'b000};
      6'h04, 6'h05: return {1'b0, 6'b010110, 3'b100, 3'b000};
      6'h02: return {1'b1, 6'b010000, 3'b000, 3'b000};
      6'h03: return {1'b1, 6'b010000, 3'b000, LINK, LINK, 1'b0};
      default: return '0;
    endcase
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 3; i++) pipe[i] = '{ex: '0, mem: '0, wb: '0, dst: '0};
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic br);
    bus.id_valid = v; bus.opcode = op; bus.funct = fn;
    bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd; bus.ex_branch_taken = br;
  endtask

  // Called just after a falling edge; checks, clocks once, returns at the next falling edge.
  task automatic step(input logic v, input logic [5:0] op, input logic [5:0] fn,
                      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                      input logic br);
    logic [12:0] d;
    logic [4:0]  dst;
    logic        hz, e_stall, e_jump;
    stage_t      nxt;
    drive(v, op, fn, rs, rt, rd, br);
    #1;
    d   = ref_dec(op, fn);
    dst = (LINK && op == 6'h03) ? 5'd31 : (d[11] ? rd : rt);
    hz  = v && pipe[0].mem[1] && (pipe[0].dst != 5'd0) &&
          (pipe[0].dst == rs || pipe[0].dst == rt);
    e_stall = hz && !br;
    e_jump  = d[12] && v && !e_stall && !br;
    chk("stall",    32'(bus.stall),    32'(e_stall));
    chk("flush",    32'(bus.flush),    32'(br));
    chk("id_jump",  32'(bus.id_jump),  32'(e_jump));
    chk("ex_ctrl",  32'(bus.ex_ctrl),  32'(pipe[0].ex));
    chk("mem_ctrl", 32'(bus.mem_ctrl), 32'(pipe[1].mem));
    chk("wb_ctrl",  32'(bus.wb_ctrl),  32'(pipe[2].wb[WBW-1:0]));
    chk("wb_dst",   32'(bus.wb_dst),   32'(pipe[2].dst));
    nxt = '{ex: '0, mem: '0, wb: '0, dst: '0};
    if (v && !e_stall && !br) begin
      nxt.ex  = d[11:6];
      nxt.mem = d[5:3];
      nxt.wb  = d[2:0];
      nxt.dst = dst;
      if (dst == 5'd0) nxt.wb[1] = 1'b0;
    end
    @(posedge clk);
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = nxt;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ex"},  32'(bus.ex_ctrl),  32'd0);
    chk({tag, "_mem"}, 32'(bus.mem_ctrl), 32'd0);
    chk({tag, "_wb"},  32'(bus.wb_ctrl),  32'd0);
    chk({tag, "_dst"}, 32'(bus.wb_dst),   32'd0);
  endtask

  logic [5:0] ops [14];
  logic [5:0] fns [13];

  initial begin
    ops = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h0a, 6'h0c, 6'h0d, 6'h0e,
            6'h23, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h03};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h00,
            6'h02, 6'h03, 6'h2a, 6'h08, 6'h09, 6'h3f};
    drive(1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0);
    clear_model();

    // Reset state
    #2;
    chk_zero("reset");
    chk("reset_stall", 32'(bus.stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // addi rt=2, then idle: ex_ctrl after one cycle, wb after three
    step(1'b1, 6'h08, 6'h00, 5'd1, 5'd2, 5'd9, 1'b0);
    #1 chk("addi_ex_c1", 32'(bus.ex_ctrl), 32'h12);
    idle();
    idle();
    #1 chk("addi_wb_c3", 32'(bus.wb_ctrl[1:0]), 32'h2);
    chk("addi_dst_c3", 32'(bus.wb_dst), 32'd2);
    idle();

    // Load-use: lw rt=5 then add rs=5
    step(1'b1, 6'h23, 6'h00, 5'd1, 5'd5, 5'd0, 1'b0);
    step(1'b1, 6'h00, 6'h20, 5'd5, 5'd6, 5'd7, 1'b0);
    #1 chk("lu_bubble", 32'(bus.ex_ctrl), 32'd0);
    step(1'b1, 6'h00, 6'h20, 5'd5, 5'd6, 5'd7, 1'b0);
    #1 chk("lu_redecode", 32'(bus.ex_ctrl), 32'h22);
    idle(); idle(); idle();

    // Taken branch together with a load-use condition
    step(1'b1, 6'h23, 6'h00, 5'd1, 5'd5, 5'd0, 1'b0);
    step(1'b1, 6'h00, 6'h20, 5'd5, 5'd6, 5'd7, 1'b1);
    #1 chk("flush_bubble", 32'(bus.ex_ctrl), 32'd0);
    idle(); idle(); idle();

    // Unknown opcode, unknown funct, and a write to r0
    step(1'b1, 6'h3f, 6'h20, 5'd1, 5'd2, 5'd3, 1'b0);
    step(1'b1, 6'h00, 6'h3f, 5'd1, 5'd2, 5'd3, 1'b0);
    step(1'b1, 6'h08, 6'h00, 5'd1, 5'd0, 5'd3, 1'b0);
    idle();
    #1 chk("unk_wb", 32'(bus.wb_ctrl), 32'd0);
    idle();
    #1 chk("r0_regwrite", 32'(bus.wb_ctrl[1]), 32'd0);
    idle();

    // jal: link destination only with the link feature
    step(1'b1, 6'h03, 6'h00, 5'd1, 5'd4, 5'd6, 1'b0);
    idle(); idle();
    #1 chk("jal_regwrite", 32'(bus.wb_ctrl[1]), 32'(LINK));
    chk("jal_dst", 32'(bus.wb_dst), LINK ? 32'd31 : 32'd4);
    idle();

    // Reset asserted mid-stall
    step(1'b1, 6'h23, 6'h00, 5'd2, 5'd3, 5'd0, 1'b0);
    drive(1'b1, 6'h00, 6'h22, 5'd3, 5'd1, 5'd8, 1'b0);
    #1 chk("pre_rst_stall", 32'(bus.stall), 32'd1);
    rst_n = 1'b0;
    #1 chk("rst_stall_drop", 32'(bus.stall), 32'd0);
    chk_zero("async_rst");
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 6'h0d, 6'h00, 5'd2, 5'd6, 5'd0, 1'b0);
    #1 chk("post_rst_ori", 32'(bus.ex_ctrl), 32'h11);

    // Random traffic with small register indices to provoke hazards
    for (int n = 0; n < 400; n++) begin
      logic [5:0] op, fn;
      op = ($urandom_range(0, 15) == 0) ? 6'($urandom) : ops[$urandom_range(0, 13)];
      fn = fns[$urandom_range(0, 12)];
      step($urandom_range(0, 9) != 0, op, fn,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           $urandom_range(0, 9) == 0);
      if (n == 200) begin
        #2 rst_n = 1'b0;
        #1 chk_zero("rand_rst");
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
